dc_svc: RTL and testbench



---
 rtl/dc_svc_pkg.sv | 24 ++
 rtl/svc_sync.sv | 26 ++
 rtl/dc_svc.sv | 107 ++++++++++
 tb/tb_dc_svc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dc_svc_pkg.sv
// Shared definitions for the service-word generator: DAL bit positions of the
// service word and the word read back when every source is inactive.
package dc_svc_pkg;

    localparam int SVC_W     = 16;
    localparam int N_ASYNC   = 9;

    localparam int SVC_EVNT  = 12;
    localparam int SVC_IRQ4  = 11;
    localparam int SVC_IRQ5  = 10;
    localparam int SVC_IRQ6  = 9;
    localparam int SVC_IRQ7  = 8;
    localparam int SVC_ACLO  = 7;
    localparam int SVC_GND   = 6;
    localparam int SVC_HALT  = 5;
    localparam int SVC_CCE   = 4;
    localparam int SVC_MMU   = 3;
    localparam int SVC_PAR   = 2;
    localparam int SVC_TMO   = 1;
    localparam int SVC_DCLO  = 0;

    localparam logic [SVC_W-1:0] SVC_IDLE = 16'h009D;

endpackage

// File: rtl/svc_sync.sv
// Multi-bit flop-chain synchronizer; each bit is an independent level, so no
// cross-bit coherency is implied at the output.
module svc_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/dc_svc.sv
// Service-word generator: synchronizes board conditions, latches transient
// events as sticky flags and presents a one-cycle snapshot on AD per read.
module dc_svc
    import dc_svc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LTC_EDGE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  irq,
    input  logic        evnt,
    input  logic        ltc_ie,
    input  logic        aclo,
    input  logic        dclo,
    input  logic        halt,
    input  logic        cc_err,
    input  logic        bus_tmo,
    input  logic        par_err,
    input  logic        mmu_abt,
    output logic [15:0] ad_out,
    output logic        ad_oe
);

    logic [N_ASYNC-1:0] async_s;
    logic [3:0]         irq_s;
    logic               evnt_s, aclo_s, dclo_s, halt_s, cc_err_s;

    svc_sync #(
        .WIDTH  (N_ASYNC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({cc_err, halt, dclo, aclo, evnt, irq}),
        .q_o (async_s)
    );

    assign irq_s    = async_s[3:0];
    assign evnt_s   = async_s[4];
    assign aclo_s   = async_s[5];
    assign dclo_s   = async_s[6];
    assign halt_s   = async_s[7];
    assign cc_err_s = async_s[8];

    logic              tmo_f_q, par_f_q, abt_f_q, evt_f_q, evnt_prev_q;
    logic              tmo_f_d, par_f_d, abt_f_d, evt_f_d;
    logic [SVC_W-1:0]  ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic [SVC_W-1:0]  snap;
    logic              evt_rise;

    assign evt_rise = evnt_s & ~evnt_prev_q;

    always_comb begin
        snap            = '0;
        snap[SVC_EVNT]  = (LTC_EDGE != 0) ? evt_f_q : (evnt_s & ltc_ie);
        snap[SVC_IRQ4]  = irq_s[0];
        snap[SVC_IRQ5]  = irq_s[1];
        snap[SVC_IRQ6]  = irq_s[2];
        snap[SVC_IRQ7]  = irq_s[3];
        snap[SVC_ACLO]  = ~aclo_s;
        snap[SVC_GND]   = 1'b0;
        snap[SVC_HALT]  = halt_s;
        snap[SVC_CCE]   = ~cc_err_s;
        snap[SVC_MMU]   = ~abt_f_q;
        snap[SVC_PAR]   = ~par_f_q;
        snap[SVC_TMO]   = tmo_f_q;
        // DCLO reads 1 while DC is good, giving the 16'h009D idle word.
        snap[SVC_DCLO]  = ~dclo_s;
    end

    // A read clears what it captured; a pulse in the same cycle re-sets the flag.
    always_comb begin
        tmo_f_d  = (tmo_f_q & ~rd_req) | bus_tmo;
        par_f_d  = (par_f_q & ~rd_req) | par_err;
        abt_f_d  = (abt_f_q & ~rd_req) | mmu_abt;
        evt_f_d  = ltc_ie & (LTC_EDGE != 0) & ((evt_f_q & ~rd_req) | evt_rise);
        ad_out_d = rd_req ? snap : ad_out_q;
        ad_oe_d  = rd_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_f_q     <= 1'b0;
            par_f_q     <= 1'b0;
            abt_f_q     <= 1'b0;
            evt_f_q     <= 1'b0;
            evnt_prev_q <= 1'b0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
        end else begin
            tmo_f_q     <= tmo_f_d;
            par_f_q     <= par_f_d;
            abt_f_q     <= abt_f_d;
            evt_f_q     <= evt_f_d;
            evnt_prev_q <= evnt_s;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_dc_svc.sv
// Bench for dc_svc: directed scenarios plus random traffic, with expected
// service words queued at issue time and compared whenever ad_oe is high.
module tb_dc_svc;

    localparam int SYNC_STAGES = 2;
    localparam int LTC_EDGE    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [3:0]  irq = '0;
    logic        evnt = 1'b0, ltc_ie = 1'b1, aclo = 1'b0, dclo = 1'b0;
    logic        halt = 1'b0, cc_err = 1'b0;
    logic        bus_tmo = 1'b0, par_err = 1'b0, mmu_abt = 1'b0;
    logic [15:0] ad_out;
    logic        ad_oe;

    dc_svc #(
        .SYNC_STAGES (SYNC_STAGES),
        .LTC_EDGE    (LTC_EDGE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .irq     (irq),
        .evnt    (evnt),
        .ltc_ie  (ltc_ie),
        .aclo    (aclo),
        .dclo    (dclo),
        .halt    (halt),
        .cc_err  (cc_err),
        .bus_tmo (bus_tmo),
        .par_err (par_err),
        .mmu_abt (mmu_abt),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    // Reference state: board levels as driven, sticky events as booleans.
    logic [3:0] m_irq = '0;
    bit m_evnt = 0, m_ltc = 1, m_aclo = 0, m_dclo = 0, m_halt = 0, m_cce = 0;
    bit m_tmo = 0, m_par = 0, m_abt = 0, m_evt = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word();
        return {3'b000, m_evt, m_irq[0], m_irq[1], m_irq[2], m_irq[3],
                !m_aclo, 1'b0, m_halt, !m_cce, !m_abt, !m_par, m_tmo, !m_dclo};
    endfunction

    // One clock: optional read plus optional event pulses.
    task automatic step(input bit rd, input bit tmo, input bit par, input bit abt,
                        input bit use_c, input logic [15:0] c);
        rd_req  = rd;
        bus_tmo = tmo;
        par_err = par;
        mmu_abt = abt;
        if (rd) begin
            exp_q.push_back(use_c ? c : model_word());
            m_tmo = 0; m_par = 0; m_abt = 0; m_evt = 0;
        end
        if (tmo) m_tmo = 1;
        if (par) m_par = 1;
        if (abt) m_abt = 1;
        @(posedge clk); #1;
        rd_req = 0; bus_tmo = 0; par_err = 0; mmu_abt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] c);
        step(1, 0, 0, 0, 1, c);
    endtask

    // Change board levels, then wait until they have crossed the synchronizer.
    task automatic set_async(input logic [3:0] i, input bit ev, input bit a, input bit d,
                             input bit h, input bit ce, input bit l);
        if (!l) m_evt = 0;
        else if (ev && !m_evnt) m_evt = 1;
        m_irq = i; m_evnt = ev; m_aclo = a; m_dclo = d; m_halt = h; m_cce = ce; m_ltc = l;
        irq = i; evnt = ev; aclo = a; dclo = d; halt = h; cc_err = ce; ltc_ie = l;
        idle(SYNC_STAGES + 2);
    endtask

    always @(negedge clk) begin
        if (ad_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ad_oe: ad_out=%h with no read outstanding", ad_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("svc_word", ad_out, e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ad_oe", {15'h0, ad_oe}, 16'h0);
        check("reset_ad_out", ad_out, 16'h0000);
        rst = 1'b0;

        // Idle word and one-cycle drive window, then ad_out holds.
        idle(SYNC_STAGES + 1);
        rd(16'h009D);
        idle(2);
        check("idle_oe_low", {15'h0, ad_oe}, 16'h0);
        check("idle_hold", ad_out, 16'h009D);

        // Levels are reported as-is and survive reads.
        set_async(4'b0101, 0, 1, 0, 1, 0, 1);
        rd(16'h0A3D);
        idle(1);
        rd(16'h0A3D);
        set_async(4'b0000, 0, 0, 0, 0, 0, 1);

        // Sticky flags, cleared by the read that reports them.
        step(0, 1, 1, 0, 0, 16'h0);
        rd(16'h009B);
        rd(16'h009D);

        // A pulse coinciding with the clearing read keeps the flag set.
        step(0, 0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 1, 1, 16'h0095);
        rd(16'h0095);
        rd(16'h009D);

        // Line clock: one report per rising edge, nothing while disabled.
        set_async(4'b0000, 1, 0, 0, 0, 0, 1);
        idle(6);
        rd(16'h109D);
        rd(16'h009D);
        set_async(4'b0000, 0, 0, 0, 0, 0, 0);
        set_async(4'b0000, 1, 0, 0, 0, 0, 0);
        idle(6);
        rd(16'h009D);
        set_async(4'b0000, 0, 0, 0, 0, 0, 1);

        // Reset right after a read drops ad_oe and discards the new timeout.
        step(1, 1, 0, 0, 1, 16'h009D);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_read_oe", {15'h0, ad_oe}, 16'h0);
        rst = 1'b0;
        m_tmo = 0; m_par = 0; m_abt = 0;
        m_evt = m_ltc && m_evnt;
        idle(SYNC_STAGES + 1);
        rd(16'h009D);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                set_async(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
            end else begin
                step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0, 16'h0);
            end
        end

        idle(3);
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
